// File: rtl/ahb_reg_slave.sv
// AHB-Lite register bank slave: NUM_REGS x 32-bit registers with a read-only ID at index 0,
// a fixed number of data-phase wait states and a two-cycle ERROR response for bad addresses.
module ahb_reg_slave #(
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic                     hclk,
  input  logic                     hrst_n,
  input  logic                     hsel,
  input  logic [31:0]              haddr,
  input  logic [1:0]               htrans,
  input  logic                     hwrite,
  input  logic [3:0]               hprot,
  input  logic [31:0]              hwdata,
  output logic [31:0]              hrdata,
  output logic                     hready,
  output logic [1:0]               hresp,
  output logic [32*NUM_REGS-1:0]   reg_q
);

  localparam int   IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic ZERO_WAIT = (WAIT_STATES == 0);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             wr_q, wr_d;
  logic [31:0]      regs [NUM_REGS];

  logic [31:0]      off;
  logic [IDX_W-1:0] dec_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [31:0]      rd_val;
  logic             addr_ok;
  logic             accept;
  logic             done;
  logic             commit;
  logic             rd_load;
  logic             unused_ok;

  assign unused_ok = ^{hprot, htrans[0]};

  // Address decode for the address phase currently on the bus
  assign off     = haddr - BASE_ADDR;
  assign dec_idx = off[IDX_W+1:2];
  assign addr_ok = (off[1:0] == 2'b00) && (off[31:2] < 30'(NUM_REGS));

  assign hready = (state_q == S_IDLE) || (state_q == S_ERR2) ||
                  ((state_q == S_DATA) && (cnt_q == 3'd0));
  assign hresp  = ((state_q == S_ERR1) || (state_q == S_ERR2)) ? 2'b01 : 2'b00;

  assign accept = hsel & htrans[1] & hready;
  assign done   = (state_q == S_DATA) && (cnt_q == 3'd0);
  assign commit = done & wr_q & (idx_q != '0);

  // hrdata is loaded on the edge that enters the completing cycle of a read
  assign rd_load = (accept & addr_ok & ~hwrite & ZERO_WAIT) |
                   ((state_q == S_DATA) & (cnt_q == 3'd1) & ~wr_q);
  assign rd_idx  = accept ? dec_idx : idx_q;

  always_comb begin
    rd_val = regs[rd_idx];
    if (rd_idx == '0) begin
      rd_val = ID_VALUE;
    end else if (commit && (idx_q == rd_idx)) begin
      // back-to-back read of a register being written on this same edge
      rd_val = hwdata;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    case (state_q)
      S_DATA: begin
        if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
        else               state_d = S_IDLE;
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      idx_d = dec_idx;
      wr_d  = hwrite;
      if (addr_ok) begin
        state_d = S_DATA;
        cnt_d   = 3'(WAIT_STATES);
      end else begin
        state_d = S_ERR1;
      end
    end
  end

  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      hrdata  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      if (rd_load) hrdata <= rd_val;
    end
  end

  // Register bank; entry 0 only ever holds the ID constant
  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= (i == 0) ? ID_VALUE : 32'h0;
    end else if (commit) begin
      regs[idx_q] <= hwdata;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regq
    assign reg_q[32*g +: 32] = regs[g];
  end

endmodule

// File: tb/tb_ahb_reg_slave.sv
// Bench for ahb_reg_slave: three instances (1, 0 and 3 wait states) driven by one AHB master model,
// a transfer table with expected responses and a scoreboard queue popped at each completion.
module tb_ahb_reg_slave;

  localparam int NR = 16;
  localparam logic [31:0] ID = 32'hA5B0_0001;

  logic              hclk = 1'b0;
  logic              hrst_n;
  logic              hsel;
  logic [31:0]       haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [3:0]        hprot;
  logic [31:0]       hwdata;
  logic              hsel_v   [3];
  logic              hready_v [3];
  logic [1:0]        hresp_v  [3];
  logic [31:0]       hrdata_v [3];
  logic [32*NR-1:0]  regq_v   [3];
  int                cur;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  typedef struct {
    int          id;
    logic [1:0]  resp;
    int          waits;
    logic [31:0] rd;
    logic        chk_rd;
  } exp_t;

  vec_t tv [15];
  exp_t sbq [$];
  int   errors = 0;
  int   checks = 0;

  always #5 hclk = ~hclk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign hsel_v[g] = hsel && (cur == g);
    ahb_reg_slave #(
      .NUM_REGS(NR),
      .WAIT_STATES(g == 0 ? 1 : (g == 1 ? 0 : 3))
    ) u_dut (
      .hclk(hclk), .hrst_n(hrst_n), .hsel(hsel_v[g]), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hprot(hprot), .hwdata(hwdata), .hrdata(hrdata_v[g]),
      .hready(hready_v[g]), .hresp(hresp_v[g]), .reg_q(regq_v[g])
    );
  end

  function automatic int ws_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_reset_regs(input int k, input string tag);
    check($sformatf("%s reg0", tag), regq_v[k][31:0], ID);
    for (int i = 1; i < NR; i++)
      check($sformatf("%s reg%0d", tag, i), regq_v[k][32*i +: 32], 32'h0);
  endtask

  task automatic drive_addr(input int i);
    exp_t e;
    hsel     = 1'b1;
    htrans   = 2'b10;
    hwrite   = tv[i].wr;
    haddr    = tv[i].addr;
    e.id     = i;
    e.resp   = tv[i].err ? 2'b01 : 2'b00;
    e.waits  = tv[i].err ? 1 : ws_of(cur);
    e.rd     = tv[i].rd;
    e.chk_rd = !tv[i].wr || tv[i].err;
    sbq.push_back(e);
  endtask

  task automatic bus_idle();
    hsel   = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
  endtask

  // Pipelined master: next address phase overlaps the current data phase
  task automatic run_seq(input int first, input int last, output int cyc);
    int   nxt;
    int   dp;
    int   waits;
    logic rdy;
    exp_t e;
    nxt = first; dp = -1; waits = 0; cyc = 0;
    @(negedge hclk);
    drive_addr(nxt);
    while ((nxt <= last || dp >= 0) && cyc < 100) begin
      rdy = hready_v[cur];
      if (dp >= 0) begin
        if (rdy) begin
          if (tv[dp].wr) hwdata = tv[dp].wd;
          if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_empty: got no entry for transfer %0d", dp);
          end else begin
            e = sbq.pop_front();
            check($sformatf("t%0d hresp", e.id), 32'(hresp_v[cur]), 32'(e.resp));
            check($sformatf("t%0d waits", e.id), 32'(waits), 32'(e.waits));
            if (e.chk_rd) check($sformatf("t%0d hrdata", e.id), hrdata_v[cur], e.rd);
          end
        end else begin
          check($sformatf("t%0d wait hresp", dp), 32'(hresp_v[cur]),
                tv[dp].err ? 32'h1 : 32'h0);
          hwdata = $urandom;
        end
      end
      @(posedge hclk);
      #1;
      cyc++;
      if (rdy) begin
        dp = -1;
        if (nxt <= last) begin
          dp = nxt;
          nxt++;
          waits = 0;
          if (tv[dp].wr) hwdata = ~tv[dp].wd;
          if (nxt <= last) drive_addr(nxt);
          else             bus_idle();
        end
      end else begin
        waits++;
      end
      @(negedge hclk);
    end
    if (nxt <= last || dp >= 0) begin
      checks++; errors++;
      $display("FAIL seq_timeout: got pending transfer %0d required none", dp);
      bus_idle();
    end
  endtask

  initial begin
    int c;
    hrst_n = 1'b0; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
    hprot = 4'h3; hwdata = '0; cur = 0;

    //          wr    addr           wdata          expected hrdata err
    tv[0]  = '{1'b0, 32'h4000_0000, 32'h0,         ID,            1'b0};
    tv[1]  = '{1'b1, 32'h4000_0008, 32'hDEAD_BEEF, 32'h0,         1'b0};
    tv[2]  = '{1'b0, 32'h4000_0008, 32'h0,         32'hDEAD_BEEF, 1'b0};
    tv[3]  = '{1'b1, 32'h4000_0000, 32'h0000_1234, 32'h0,         1'b0};
    tv[4]  = '{1'b0, 32'h4000_0000, 32'h0,         ID,            1'b0};
    tv[5]  = '{1'b0, 32'h4000_0040, 32'h0,         ID,            1'b1};
    tv[6]  = '{1'b0, 32'h4000_0006, 32'h0,         ID,            1'b1};
    tv[7]  = '{1'b1, 32'h4000_003C, 32'hCAFE_F00D, 32'h0,         1'b0};
    tv[8]  = '{1'b0, 32'h4000_003C, 32'h0,         32'hCAFE_F00D, 1'b0};
    tv[9]  = '{1'b1, 32'h3FFF_FFFC, 32'h1111_2222, 32'hCAFE_F00D, 1'b1};
    tv[10] = '{1'b0, 32'h4000_0008, 32'h0,         32'hDEAD_BEEF, 1'b0};
    tv[11] = '{1'b1, 32'h4000_0004, 32'h0000_0055, 32'h0,         1'b0};
    tv[12] = '{1'b0, 32'h4000_0004, 32'h0,         32'h0000_0055, 1'b0};
    tv[13] = '{1'b1, 32'h4000_000C, 32'h0BAD_CAFE, 32'h0,         1'b0};
    tv[14] = '{1'b0, 32'h4000_000C, 32'h0,         32'h0BAD_CAFE, 1'b0};

    repeat (3) @(posedge hclk);
    @(negedge hclk);
    check("rst hready", 32'(hready_v[0]), 32'h1);
    check("rst hresp",  32'(hresp_v[0]),  32'h0);
    check("rst hrdata", hrdata_v[0],      32'h0);
    check_reset_regs(0, "rst");
    hrst_n = 1'b1;

    // 1 wait state: reads, writes, ID protection, decode errors, pipelined
    cur = 0;
    run_seq(0, 10, c);
    check("ws1 reg0",  regq_v[0][31:0],    ID);
    check("ws1 reg1",  regq_v[0][63:32],   32'h0);
    check("ws1 reg2",  regq_v[0][95:64],   32'hDEAD_BEEF);
    check("ws1 reg3",  regq_v[0][127:96],  32'h0);
    check("ws1 reg15", regq_v[0][511:480], 32'hCAFE_F00D);

    // zero wait states: back-to-back write then read of the same register
    cur = 1;
    run_seq(11, 12, c);
    check("ws0 cycles", 32'(c), 32'd3);
    check("ws0 reg1", regq_v[1][63:32], 32'h0000_0055);

    // three wait states, hwdata scrambled until the completion cycle
    cur = 2;
    run_seq(13, 14, c);
    check("ws3 cycles", 32'(c), 32'd9);
    check("ws3 reg3", regq_v[2][127:96], 32'h0BAD_CAFE);

    // reset in the middle of a write data phase
    cur = 0;
    @(negedge hclk);
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h4000_0004;
    @(posedge hclk);
    #1;
    bus_idle();
    hwdata = 32'h0000_0077;
    @(negedge hclk);
    check("mid wait hready", 32'(hready_v[0]), 32'h0);
    hrst_n = 1'b0;
    #1;
    check("mid rst hready", 32'(hready_v[0]), 32'h1);
    check("mid rst hresp",  32'(hresp_v[0]),  32'h0);
    check("mid rst hrdata", hrdata_v[0],      32'h0);
    check_reset_regs(0, "mid rst");
    @(negedge hclk);
    hrst_n = 1'b1;
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    check("post rst reg1",   regq_v[0][63:32], 32'h0);
    check("post rst hready", 32'(hready_v[0]), 32'h1);

    check("sb drained", 32'(sbq.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
